// File: rtl/uart_host_ctrl.sv
// Host-side sequencer for the uart_top config bus: programs divider/control after reset,
// pushes client TX bytes as TXDATA+START writes and drains RXDATA into a 1-entry buffer.
module uart_host_ctrl #(
  parameter logic [4:0]  ADDR_CTRL   = 5'd0,
  parameter logic [4:0]  ADDR_DIV    = 5'd1,
  parameter logic [4:0]  ADDR_TXDATA = 5'd2,
  parameter logic [4:0]  ADDR_RXDATA = 5'd3,
  parameter logic [4:0]  ADDR_CMD    = 5'd4,
  parameter int unsigned TX_TIMEOUT  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] div_i,
  input  logic        crc_en_i,
  input  logic        reconfig_i,
  input  logic        tx_valid_i,
  input  logic [7:0]  tx_data_i,
  output logic        tx_ready_o,
  output logic        rx_valid_o,
  output logic [7:0]  rx_data_o,
  input  logic        rx_ready_i,
  output logic        cfg_cs_o,
  output logic        cfg_we_o,
  output logic [4:0]  cfg_addr_o,
  output logic [31:0] cfg_data_o,
  input  logic [31:0] cfg_data_i,
  input  logic        tx_int_i,
  input  logic        rx_int_i,
  input  logic        err_int_i,
  output logic        busy_o,
  output logic [1:0]  err_o
);

  localparam int unsigned     CNT_W    = (TX_TIMEOUT > 2) ? $clog2(TX_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TX_TIMEOUT - 2);

  typedef enum logic [2:0] {
    INIT_DIV, INIT_CTRL, IDLE, RX_RD, RX_CAP, TX_WR, TX_GO, TX_WAIT
  } state_t;

  state_t            state, state_d;
  logic              armed;
  logic              reinit_pend, rx_pend;
  logic [CNT_W-1:0]  cnt;
  logic              cs_d, we_d, rdy_d;
  logic [4:0]        addr_d;
  logic [31:0]       data_d;
  logic              take_rx, take_reinit, cap, tmo;
  logic              rx_req, reinit_req;
  logic              unused_cfg;

  assign unused_cfg = ^cfg_data_i[31:8];
  assign rx_req     = rx_pend | rx_int_i;
  assign reinit_req = reinit_pend | reconfig_i;

  // Next state plus the bus strobe that coincides with the state being entered.
  always_comb begin
    state_d     = state;
    cs_d        = 1'b0;
    we_d        = 1'b0;
    addr_d      = '0;
    data_d      = '0;
    rdy_d       = 1'b0;
    take_rx     = 1'b0;
    take_reinit = 1'b0;
    cap         = 1'b0;
    tmo         = 1'b0;
    case (state)
      INIT_DIV: begin
        cs_d = 1'b1;
        we_d = 1'b1;
        if (!armed) begin
          // first cycle out of reset has no strobe yet; the DIV write follows it
          addr_d = ADDR_DIV;
          data_d = {16'b0, div_i};
        end else begin
          state_d = INIT_CTRL;
          addr_d  = ADDR_CTRL;
          data_d  = {29'b0, crc_en_i, 2'b11};
        end
      end
      INIT_CTRL: state_d = IDLE;
      IDLE: begin
        if (reinit_req) begin
          take_reinit = 1'b1;
          state_d     = INIT_DIV;
          cs_d        = 1'b1;
          we_d        = 1'b1;
          addr_d      = ADDR_DIV;
          data_d      = {16'b0, div_i};
        end else if (rx_req) begin
          take_rx = 1'b1;
          state_d = RX_RD;
          cs_d    = 1'b1;
          addr_d  = ADDR_RXDATA;
        end else if (tx_valid_i) begin
          state_d = TX_WR;
          rdy_d   = 1'b1;
          cs_d    = 1'b1;
          we_d    = 1'b1;
          addr_d  = ADDR_TXDATA;
          data_d  = {24'b0, tx_data_i};
        end
      end
      RX_RD:  state_d = RX_CAP;
      RX_CAP: begin
        state_d = IDLE;
        cap     = 1'b1;
      end
      TX_WR: begin
        state_d = TX_GO;
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = ADDR_CMD;
        data_d  = 32'h1;
      end
      TX_GO: state_d = TX_WAIT;
      TX_WAIT: begin
        if (tx_int_i) begin
          state_d = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_d = IDLE;
          tmo     = 1'b1;
        end
      end
      default: state_d = INIT_DIV;
    endcase
  end

  // State, registered outputs, pending flags, timeout counter and rx buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= INIT_DIV;
      armed       <= 1'b0;
      reinit_pend <= 1'b0;
      rx_pend     <= 1'b0;
      cnt         <= '0;
      cfg_cs_o    <= 1'b0;
      cfg_we_o    <= 1'b0;
      cfg_addr_o  <= '0;
      cfg_data_o  <= '0;
      tx_ready_o  <= 1'b0;
      busy_o      <= 1'b0;
      rx_valid_o  <= 1'b0;
      rx_data_o   <= '0;
      err_o       <= '0;
    end else begin
      state      <= state_d;
      armed      <= 1'b1;
      cfg_cs_o   <= cs_d;
      cfg_we_o   <= we_d;
      cfg_addr_o <= addr_d;
      cfg_data_o <= data_d;
      tx_ready_o <= rdy_d;
      busy_o     <= (state_d != IDLE);
      // a fresh event arriving while an older one is taken stays pending
      reinit_pend <= take_reinit ? (reinit_pend & reconfig_i) : reinit_req;
      rx_pend     <= take_rx ? (rx_pend & rx_int_i) : rx_req;
      if (state == TX_GO) begin
        cnt <= '0;
      end else if (state == TX_WAIT && cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
      if (cap && !rx_valid_o) begin
        rx_data_o  <= cfg_data_i[7:0];
        rx_valid_o <= 1'b1;
      end
      err_o[0] <= (err_o[0] & ~reconfig_i) | tmo;
      err_o[1] <= (err_o[1] & ~reconfig_i) | err_int_i | (cap & rx_valid_o);
    end
  end

endmodule
